// File: rtl/random_checker.sv
// random_checker: receive-side checker for the on-chip Galois LFSR random stream.
// Locks onto the incoming stream without a shared seed, then flywheels its own
// prediction and counts mismatching words while locked.
// Optional build macro: RANDOM_CHECKER_BITERR_EN -- when defined, each locked
// mismatch adds the number of differing bits to ERR_COUNT instead of 1.
module random_checker #(
  parameter int                DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] POLY         = DWIDTH'(32'h80200003),
  parameter int                LOCK_COUNT   = 8,
  parameter int                UNLOCK_COUNT = 4,
  parameter int                CWIDTH       = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic              IN_VALID,
  input  logic [DWIDTH-1:0] IN_DATA,
  output logic              LOCKED,
  output logic              ERR_PULSE,
  output logic [CWIDTH-1:0] ERR_COUNT,
  output logic [DWIDTH-1:0] EXPECT
);

  // Width needed to hold a popcount of DWIDTH bits, and a sum wide enough
  // that adding the increment to the counter can never overflow silently.
  localparam int PW = $clog2(DWIDTH + 1);
  localparam int SW = ((CWIDTH > PW) ? CWIDTH : PW) + 1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        match_cnt_q, match_cnt_d;
  logic [7:0]        miss_cnt_q, miss_cnt_d;
  logic [DWIDTH-1:0] expect_q, expect_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CWIDTH-1:0] err_count_q, err_count_d;

  logic [DWIDTH-1:0] diff;
  logic              word_match;
  logic              count_inc;
  logic [SW-1:0]     inc_amt;
  logic [SW-1:0]     count_sum;
  logic [CWIDTH-1:0] count_sat;

  // One Galois LFSR step: shift right, fold the feedback mask in when bit 0 was set.
  function automatic logic [DWIDTH-1:0] lfsr_nxt(input logic [DWIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? POLY : '0);
  endfunction

  assign diff       = IN_DATA ^ expect_q;
  assign word_match = (diff == '0);

`ifdef RANDOM_CHECKER_BITERR_EN
  // Bit-error mode: increment is the number of bits that differ from the prediction.
  always_comb begin
    inc_amt = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      inc_amt = inc_amt + SW'(diff[i]);
    end
  end
`else
  // Word-error mode: every mismatching word counts once.
  assign inc_amt = SW'(1);
`endif

  // Saturating add: clamp to all-ones rather than wrapping.
  assign count_sum = SW'(err_count_q) + inc_amt;
  assign count_sat = (count_sum > SW'({CWIDTH{1'b1}})) ? {CWIDTH{1'b1}}
                                                       : count_sum[CWIDTH-1:0];

  // Next-state logic: search for a seed, verify successive words, then flywheel.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    expect_d    = expect_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    count_inc   = 1'b0;
    err_count_d = err_count_q;

    if (IN_VALID) begin
      case (state_q)
        ST_SEARCH: begin
          // Zero is the LFSR lock-up state and can never be a legal seed.
          if (IN_DATA != '0) begin
            expect_d    = lfsr_nxt(IN_DATA);
            match_cnt_d = 8'd0;
            state_d     = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (word_match) begin
            expect_d = lfsr_nxt(IN_DATA);
            if (match_cnt_q + 8'd1 == 8'(LOCK_COUNT)) begin
              state_d     = ST_LOCKED;
              locked_d    = 1'b1;
              match_cnt_d = 8'd0;
              miss_cnt_d  = 8'd0;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end else if (IN_DATA != '0) begin
            // A wrong but legal word is taken as a fresh seed.
            expect_d    = lfsr_nxt(IN_DATA);
            match_cnt_d = 8'd0;
          end else begin
            match_cnt_d = 8'd0;
            state_d     = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the prediction advances from itself, never from the data.
          expect_d = lfsr_nxt(expect_q);
          if (word_match) begin
            miss_cnt_d = 8'd0;
          end else begin
            err_pulse_d = 1'b1;
            count_inc   = 1'b1;
            if (miss_cnt_q + 8'd1 == 8'(UNLOCK_COUNT)) begin
              state_d    = ST_SEARCH;
              locked_d   = 1'b0;
              miss_cnt_d = 8'd0;
            end else begin
              miss_cnt_d = miss_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
        end
      endcase
    end

    // Clear wins over a same-cycle increment.
    if (CLR) begin
      err_count_d = '0;
    end else if (count_inc) begin
      err_count_d = count_sat;
    end
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_SEARCH;
      match_cnt_q <= 8'd0;
      miss_cnt_q  <= 8'd0;
      expect_q    <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      expect_q    <= expect_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign LOCKED    = locked_q;
  assign ERR_PULSE = err_pulse_q;
  assign ERR_COUNT = err_count_q;
  assign EXPECT    = expect_q;

endmodule
